// File: rtl/rom_dl_packer.sv
// Packs the HPS ROM-download byte stream into 16-bit SDRAM word writes with byte enables,
// buffers them in a small FIFO and issues them over a toggle req/ack handshake.
module rom_dl_packer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [24:0] ILV_BASE = 25'h10000,
  parameter logic [24:0] ILV_END  = 25'h18000
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_wait,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_data,
  output logic [1:0]  mem_ds,
  output logic        rom_loaded,
  output logic        done,
  output logic        overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] LvlFull = (PW + 1)'(DEPTH);
  localparam logic [PW:0] LvlWait = (PW + 1)'(DEPTH - 1);
  localparam logic [0:0]  StIdle  = 1'b0;
  localparam logic [0:0]  StWait  = 1'b1;

  logic        r_pend_vld;
  logic [22:0] r_pend_addr;
  logic [7:0]  r_pend_data;
  logic [22:0] r_fifo_addr [DEPTH];
  logic [15:0] r_fifo_data [DEPTH];
  logic [1:0]  r_fifo_ds   [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic [0:0]  r_state;
  logic        r_mem_req;
  logic        r_act_q, r_seen, r_loaded, r_done, r_ovf;

  logic        w_in_ilv;
  logic [23:0] w_ea;
  logic        w_push, w_pend_set, w_pend_clr, w_drop;
  logic [22:0] w_push_addr;
  logic [15:0] w_push_data;
  logic [1:0]  w_push_ds;
  logic        w_full, w_empty, w_ack_ok, w_pop, w_wr_en, w_rise, w_idle_all;

  // The interleaved region moves address bit 14 down to the byte-select position.
  assign w_in_ilv = (dl_addr >= ILV_BASE) && (dl_addr < ILV_END);
  assign w_ea     = w_in_ilv ? {dl_addr[23:15], dl_addr[13:0], dl_addr[14]} : dl_addr[23:0];

  always_comb begin
    w_push      = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_drop      = 1'b0;
    w_push_addr = r_pend_addr;
    w_push_data = {8'h00, r_pend_data};
    w_push_ds   = 2'b01;
    if (dl_wr) begin
      if (r_pend_vld) begin
        w_push     = 1'b1;
        w_pend_clr = 1'b1;
        if (w_ea[0] && (w_ea[23:1] == r_pend_addr)) begin
          w_push_data = {dl_data, r_pend_data};
          w_push_ds   = 2'b11;
        end else if (!w_ea[0]) begin
          w_pend_set = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end else if (w_ea[0]) begin
        w_push      = 1'b1;
        w_push_addr = w_ea[23:1];
        w_push_data = {dl_data, 8'h00};
        w_push_ds   = 2'b10;
      end else begin
        w_pend_set = 1'b1;
      end
    end else if (!dl_active && r_pend_vld) begin
      w_push     = 1'b1;
      w_pend_clr = 1'b1;
    end
  end

  assign w_full   = (r_count == LvlFull);
  assign w_empty  = (r_count == '0);
  assign w_ack_ok = (mem_ack == r_mem_req);
  // Popping on the ack-detect cycle gives back-to-back issue.
  assign w_pop    = !w_empty && ((r_state == StIdle) || ((r_state == StWait) && w_ack_ok));
  assign w_wr_en  = w_push && (!w_full || w_pop);
  assign w_rise   = dl_active && !r_act_q;
  assign w_idle_all = !dl_active && !r_pend_vld && w_empty && !w_push && (r_state == StIdle) &&
                      w_ack_ok && r_seen;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else if (w_pend_set) begin
      r_pend_vld  <= 1'b1;
      r_pend_addr <= w_ea[23:1];
      r_pend_data <= dl_data;
    end else if (w_pend_clr) begin
      r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_wr_en) begin
      r_fifo_addr[r_wptr] <= w_push_addr;
      r_fifo_data[r_wptr] <= w_push_data;
      r_fifo_ds[r_wptr]   <= w_push_ds;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_mem_req <= mem_ack;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_ds    <= '0;
    end else if (w_pop) begin
      mem_addr  <= r_fifo_addr[r_rptr];
      mem_data  <= r_fifo_data[r_rptr];
      mem_ds    <= r_fifo_ds[r_rptr];
      r_mem_req <= ~r_mem_req;
      r_state   <= StWait;
    end else if ((r_state == StWait) && w_ack_ok) begin
      r_state <= StIdle;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_act_q  <= 1'b0;
      r_seen   <= 1'b0;
      r_loaded <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_act_q <= dl_active;
      r_done  <= 1'b0;
      if (w_rise) r_seen <= 1'b1;
      if (w_drop || (w_push && w_full && !w_pop)) r_ovf <= 1'b1;
      if (w_rise) begin
        r_loaded <= 1'b0;
      end else if (w_idle_all && !r_loaded) begin
        r_loaded <= 1'b1;
        r_done   <= 1'b1;
      end
    end
  end

  assign dl_wait    = (r_count >= LvlWait);
  assign mem_req    = r_mem_req;
  assign rom_loaded = r_loaded;
  assign done       = r_done;
  assign overflow   = r_ovf;

endmodule
